// File: rtl/cpu_pkg.sv
// Shared widths and ALU operation encodings for the accumulator CPU datapath.
package cpu_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int OP_W   = 3;

  typedef enum logic [1:0] {
    ALU_PASS_A = 2'b00,
    ALU_ADD    = 2'b01,
    ALU_SUB    = 2'b10,
    ALU_PASS_B = 2'b11
  } alu_op_e;
endpackage

// File: rtl/dp_alu.sv
// Combinational 8-bit ALU: pass A, A+B, A-B, pass B, with carry-out / borrow.
module dp_alu
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [1:0]        i_op,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry
);
  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  // The extra top bit carries out of the add, and is set as a borrow when A < B.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_result = i_a;
    o_carry  = 1'b0;
    case (alu_op_e'(i_op))
      ALU_PASS_A: begin
        o_result = i_a;
        o_carry  = 1'b0;
      end
      ALU_ADD: begin
        o_result = w_sum[DATA_W-1:0];
        o_carry  = w_sum[DATA_W];
      end
      ALU_SUB: begin
        o_result = w_diff[DATA_W-1:0];
        o_carry  = w_diff[DATA_W];
      end
      ALU_PASS_B: begin
        o_result = i_b;
        o_carry  = 1'b0;
      end
      default: begin
        o_result = i_a;
        o_carry  = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/datapath.sv
// Accumulator CPU datapath: PC, IR, AC, ACII registers around dp_alu.
// Define DATAPATH_FLAGS_EN to add registered zero_flag / carry_flag outputs.
module datapath
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic              ir_on_adr,
  input  logic              pc_on_adr,
  input  logic              ld_ir,
  input  logic              ld_ac,
  input  logic              ld_pc,
  input  logic              ld_acii,
  input  logic              sel_acii,
  input  logic              sel_ir,
  input  logic              sel_zero,
  input  logic              inc_pc,
  input  logic              clr_pc,
  input  logic              source_ac,
  input  logic [1:0]        pass_add,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [OP_W-1:0]   op_code,
  output logic [ADDR_W-1:0] pc_q,
  output logic [DATA_W-1:0] ac_q,
  output logic [DATA_W-1:0] acii_q
`ifdef DATAPATH_FLAGS_EN
  ,
  output logic              zero_flag,
  output logic              carry_flag
`endif
);
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_ac;
  logic [DATA_W-1:0] r_acii;

  logic [DATA_W-1:0] w_alu_a;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry;
  logic [DATA_W-1:0] w_ir_operand;

  assign w_ir_operand = {{(DATA_W-ADDR_W){1'b0}}, r_ir[ADDR_W-1:0]};
  assign w_alu_a      = sel_zero ? '0 : r_ac;
  assign w_alu_b      = sel_acii ? r_acii : (sel_ir ? w_ir_operand : '0);

  dp_alu u_alu (
    .i_a      (w_alu_a),
    .i_b      (w_alu_b),
    .i_op     (pass_add),
    .o_result (w_alu_result),
    .o_carry  (w_alu_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc   <= '0;
      r_ir   <= '0;
      r_ac   <= '0;
      r_acii <= '0;
    end else begin
      if (clr_pc)
        r_pc <= '0;
      else if (ld_pc)
        r_pc <= r_ir[ADDR_W-1:0];
      else if (inc_pc)
        r_pc <= r_pc + ADDR_W'(1);

      if (ld_ir)
        r_ir <= mem_rdata;
      if (ld_ac)
        r_ac <= source_ac ? w_alu_result : mem_rdata;
      if (ld_acii)
        r_acii <= w_alu_result;
    end
  end

`ifdef DATAPATH_FLAGS_EN
  logic r_zero_flag;
  logic r_carry_flag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_zero_flag  <= 1'b0;
      r_carry_flag <= 1'b0;
    end else if (ld_ac || ld_acii) begin
      r_zero_flag  <= (w_alu_result == '0);
      r_carry_flag <= w_alu_carry;
    end
  end

  assign zero_flag  = r_zero_flag;
  assign carry_flag = r_carry_flag;
`else
  logic w_unused_carry;
  assign w_unused_carry = w_alu_carry;
`endif

  // ir_on_adr takes precedence so operand access can overlap a stale pc_on_adr.
  assign mem_addr  = ir_on_adr ? r_ir[ADDR_W-1:0] : (pc_on_adr ? r_pc : '0);
  assign mem_wdata = w_alu_result;
  assign mem_rd    = rd_mem;
  assign mem_wr    = wr_mem;
  assign op_code   = r_ir[DATA_W-1 -: OP_W];
  assign pc_q      = r_pc;
  assign ac_q      = r_ac;
  assign acii_q    = r_acii;
endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: stimulus queues expectations, a monitor compares at negedge.
module tb_datapath;
  logic       clk = 1'b0;
  logic       reset;
  logic       rd_mem, wr_mem, ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_pc, ld_acii;
  logic       sel_acii, sel_ir, sel_zero, inc_pc, clr_pc, source_ac;
  logic [1:0] pass_add;
  logic [7:0] mem_rdata;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_rd, mem_wr;
  logic [2:0] op_code;
  logic [4:0] pc_q;
  logic [7:0] ac_q, acii_q;
`ifdef DATAPATH_FLAGS_EN
  logic       zero_flag, carry_flag;
`endif

  datapath dut (
    .clk(clk), .reset(reset),
    .rd_mem(rd_mem), .wr_mem(wr_mem), .ir_on_adr(ir_on_adr), .pc_on_adr(pc_on_adr),
    .ld_ir(ld_ir), .ld_ac(ld_ac), .ld_pc(ld_pc), .ld_acii(ld_acii),
    .sel_acii(sel_acii), .sel_ir(sel_ir), .sel_zero(sel_zero),
    .inc_pc(inc_pc), .clr_pc(clr_pc), .source_ac(source_ac),
    .pass_add(pass_add), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .op_code(op_code), .pc_q(pc_q), .ac_q(ac_q), .acii_q(acii_q)
`ifdef DATAPATH_FLAGS_EN
    , .zero_flag(zero_flag), .carry_flag(carry_flag)
`endif
  );

  always #5 clk = ~clk;

  localparam int K_PC = 0, K_AC = 1, K_ACII = 2, K_OP = 3, K_ADDR = 4;
  localparam int K_WDATA = 5, K_WR = 6, K_RD = 7, K_ZF = 8, K_CF = 9;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [7:0] observe(int kind);
    case (kind)
      K_PC:    return {3'b000, pc_q};
      K_AC:    return ac_q;
      K_ACII:  return acii_q;
      K_OP:    return {5'b00000, op_code};
      K_ADDR:  return {3'b000, mem_addr};
      K_WDATA: return mem_wdata;
      K_WR:    return {7'b0, mem_wr};
      K_RD:    return {7'b0, mem_rd};
`ifdef DATAPATH_FLAGS_EN
      K_ZF:    return {7'b0, zero_flag};
      K_CF:    return {7'b0, carry_flag};
`endif
      default: return 8'hxx;
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t       e;
        logic [7:0] act;
        e   = sb.pop_front();
        act = observe(e.kind);
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, act, e.exp);
        end else begin
          $display("ok   %s: 0x%02h", e.name, act);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic idle();
    rd_mem = 0; wr_mem = 0; ir_on_adr = 0; pc_on_adr = 0;
    ld_ir = 0; ld_ac = 0; ld_pc = 0; ld_acii = 0;
    sel_acii = 0; sel_ir = 0; sel_zero = 0;
    inc_pc = 0; clr_pc = 0; source_ac = 0;
    pass_add = 2'b00; mem_rdata = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic expect_v(input int kind, input logic [7:0] exp, input string name);
    exp_t e;
    e.kind = kind; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic load_ac(input logic [7:0] v);
    mem_rdata = v; ld_ac = 1; tick();
  endtask

  task automatic load_ir(input logic [7:0] v);
    mem_rdata = v; ld_ir = 1; tick();
  endtask

  task automatic load_acii(input logic [7:0] v);
    load_ac(v);
    pass_add = 2'b00; ld_acii = 1; tick();
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    expect_v(K_PC, 8'h00, "reset_pc");
    expect_v(K_AC, 8'h00, "reset_ac");
    expect_v(K_ACII, 8'h00, "reset_acii");
    expect_v(K_OP, 8'h00, "reset_op");
    expect_v(K_ADDR, 8'h00, "reset_addr");
`ifdef DATAPATH_FLAGS_EN
    expect_v(K_ZF, 8'h00, "reset_zf");
    expect_v(K_CF, 8'h00, "reset_cf");
`endif
    settle();
    reset = 0;

    // Async reset mid-cycle with registers populated
    load_ir(8'h65);
    ld_pc = 1; tick();
    load_ac(8'h5A);
    expect_v(K_AC, 8'h5A, "pre_reset_ac");
    expect_v(K_PC, 8'h05, "pre_reset_pc");
    expect_v(K_OP, 8'h03, "pre_reset_op");
    settle();
    @(posedge clk); #2;
    reset = 1;
    expect_v(K_AC, 8'h00, "async_reset_ac");
    expect_v(K_PC, 8'h00, "async_reset_pc");
    expect_v(K_OP, 8'h00, "async_reset_op");
    settle();
    mem_rdata = 8'h77; ld_ac = 1; inc_pc = 1; ld_ir = 1;
    tick();
    expect_v(K_AC, 8'h00, "held_reset_ac");
    expect_v(K_PC, 8'h00, "held_reset_pc");
    expect_v(K_OP, 8'h00, "held_reset_op");
    settle();
    reset = 0;

    // Fetch from PC=3
    load_ir(8'h03);
    ld_pc = 1; tick();
    expect_v(K_PC, 8'h03, "fetch_setup_pc");
    settle();
    align();
    pc_on_adr = 1; rd_mem = 1; ld_ir = 1; inc_pc = 1; mem_rdata = 8'h47;
    expect_v(K_ADDR, 8'h03, "fetch_addr");
    expect_v(K_RD, 8'h01, "fetch_rd");
    settle();
    tick();
    expect_v(K_OP, 8'h02, "fetch_op");
    expect_v(K_PC, 8'h04, "fetch_pc");
    settle();

    // PC wrap and priority
    load_ir(8'h1F);
    ld_pc = 1; tick();
    expect_v(K_PC, 8'h1F, "pc_31");
    inc_pc = 1; tick();
    expect_v(K_PC, 8'h00, "pc_wrap");
    inc_pc = 1; tick();
    inc_pc = 1; tick();
    expect_v(K_PC, 8'h02, "pc_inc2");
    clr_pc = 1; inc_pc = 1; tick();
    expect_v(K_PC, 8'h00, "pc_clr_over_inc");
    load_ir(8'h1C);
    ld_pc = 1; inc_pc = 1; tick();
    expect_v(K_PC, 8'h1C, "pc_ld_over_inc");
    clr_pc = 1; ld_pc = 1; tick();
    expect_v(K_PC, 8'h00, "pc_clr_over_ld");
    settle();

    // Add with carry into ACII
    load_acii(8'h20);
    expect_v(K_ACII, 8'h20, "acii_setup");
    load_ac(8'hF0);
    settle();
    align();
    pass_add = 2'b01; sel_acii = 1; ld_acii = 1;
    expect_v(K_WDATA, 8'h10, "add_wdata_comb");
    settle();
    tick();
    expect_v(K_ACII, 8'h10, "add_acii");
    expect_v(K_AC, 8'hF0, "add_ac_hold");
`ifdef DATAPATH_FLAGS_EN
    expect_v(K_CF, 8'h01, "add_carry");
    expect_v(K_ZF, 8'h00, "add_zero");
`endif
    settle();

    // Subtract with borrow into AC
    load_acii(8'h07);
    load_ac(8'h05);
    pass_add = 2'b10; sel_acii = 1; source_ac = 1; ld_ac = 1; tick();
    expect_v(K_AC, 8'hFE, "sub_ac");
    expect_v(K_ACII, 8'h07, "sub_acii_hold");
`ifdef DATAPATH_FLAGS_EN
    expect_v(K_CF, 8'h01, "sub_borrow");
    expect_v(K_ZF, 8'h00, "sub_zero");
`endif
    settle();

    // Simultaneous AC/ACII load uses pre-edge operands: FE + 07 = 05
    pass_add = 2'b01; sel_acii = 1; source_ac = 1; ld_ac = 1; ld_acii = 1; tick();
    expect_v(K_AC, 8'h05, "dual_ac");
    expect_v(K_ACII, 8'h05, "dual_acii");
    settle();

    // 0 - IR operand 1 = FF
    load_ir(8'h01);
    pass_add = 2'b10; sel_zero = 1; sel_ir = 1; source_ac = 1; ld_ac = 1; tick();
    expect_v(K_AC, 8'hFF, "zero_minus_one");
`ifdef DATAPATH_FLAGS_EN
    expect_v(K_CF, 8'h01, "zm1_borrow");
`endif
    pass_add = 2'b01; sel_zero = 1; source_ac = 1; ld_ac = 1; tick();
    expect_v(K_AC, 8'h00, "zero_result");
`ifdef DATAPATH_FLAGS_EN
    expect_v(K_ZF, 8'h01, "zero_flag_set");
    expect_v(K_CF, 8'h00, "zero_carry_clr");
`endif
    settle();

    // Store: operand address and ACII on the write bus
    load_ir(8'h7A);
    load_acii(8'h33);
    settle();
    align();
    ir_on_adr = 1; pc_on_adr = 1; pass_add = 2'b11; sel_acii = 1; wr_mem = 1;
    expect_v(K_ADDR, 8'h1A, "store_addr");
    expect_v(K_WDATA, 8'h33, "store_wdata");
    expect_v(K_WR, 8'h01, "store_wr");
    expect_v(K_RD, 8'h00, "store_rd");
    expect_v(K_OP, 8'h03, "store_op");
    settle();
    tick();
    align();
    pass_add = 2'b11; sel_ir = 1;
    expect_v(K_WDATA, 8'h1A, "passb_ir");
    expect_v(K_WR, 8'h00, "idle_wr");
    settle();
    align();
    pass_add = 2'b11; sel_ir = 1; sel_acii = 1;
    expect_v(K_WDATA, 8'h33, "passb_acii_priority");
    settle();
    align();
    expect_v(K_AC, 8'h33, "store_ac_hold");
    expect_v(K_ADDR, 8'h00, "idle_addr");
    settle();

    settle();
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
